// File: rtl/cache_arbiter_pkg.sv
// Shared types and defaults for the I/D cache line arbiter.
// Holds the FSM state encoding, the grant-side record and the grant-selection rule.
package cache_arbiter_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int LINE_W_DEF = 256;
    localparam int LINE_OFF_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_I_BUSY  = 2'd1,
        ST_D_BUSY  = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    typedef enum logic {
        SIDE_I = 1'b0,
        SIDE_D = 1'b1
    } side_t;

    // On contention the side that did not win last time goes next.
    function automatic side_t pick_side(input logic req_i, input logic req_d, input side_t last);
        side_t w_side;
        if (req_i && req_d) begin
            w_side = (last == SIDE_I) ? SIDE_D : SIDE_I;
        end else if (req_d) begin
            w_side = SIDE_D;
        end else begin
            w_side = SIDE_I;
        end
        return w_side;
    endfunction

endpackage

// File: rtl/cache_arbiter_sat_counter.sv
// Saturating event counter used for the per-side grant statistics.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates instruction- and data-cache line requests onto one memory port.
// One transaction at a time; a RELEASE cycle separates consecutive grants.
module cache_arbiter
    import cache_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    output logic              m_read,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_addr,
    output logic [LINE_W-1:0] m_wdata,
    input  logic [LINE_W-1:0] m_rdata,
    input  logic              m_resp,

    output logic [31:0]       i_grant_cnt,
    output logic [31:0]       d_grant_cnt
);

    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << LINE_OFF_W) - 1);

    arb_state_t        r_state;
    arb_state_t        w_next;
    side_t             r_last;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wr;
    logic [LINE_W-1:0] r_wdata;

    logic              w_d_req;
    side_t             w_pick;
    logic              w_grant;
    logic              w_grant_i;
    logic              w_grant_d;
    logic [ADDR_W-1:0] w_addr_sel;
    logic              w_busy;

    assign w_d_req    = d_read | d_write;
    assign w_pick     = pick_side(i_read, w_d_req, r_last);
    assign w_grant    = (r_state == ST_IDLE) && (i_read || w_d_req);
    assign w_grant_i  = w_grant && (w_pick == SIDE_I);
    assign w_grant_d  = w_grant && (w_pick == SIDE_D);
    assign w_addr_sel = (w_pick == SIDE_D) ? d_addr : i_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_next = (w_pick == SIDE_D) ? ST_D_BUSY : ST_I_BUSY;
                end
            end
            ST_I_BUSY, ST_D_BUSY: begin
                if (m_resp) begin
                    w_next = ST_RELEASE;
                end
            end
            ST_RELEASE: w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // Transaction is captured once at grant; a read+write from D is treated as a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last  <= SIDE_I;
            r_addr  <= '0;
            r_wr    <= 1'b0;
            r_wdata <= '0;
        end else if (w_grant) begin
            r_last  <= w_pick;
            r_addr  <= w_addr_sel & ~OFF_MASK;
            r_wr    <= (w_pick == SIDE_D) && d_write;
            r_wdata <= (w_pick == SIDE_D) ? d_wdata : '0;
        end
    end

    always_comb begin
        w_busy  = (r_state == ST_I_BUSY) || (r_state == ST_D_BUSY);
        m_read  = w_busy && !r_wr;
        m_write = w_busy && r_wr;
        i_resp  = (r_state == ST_I_BUSY) && m_resp;
        d_resp  = (r_state == ST_D_BUSY) && m_resp;
        i_rdata = i_resp ? m_rdata : '0;
        d_rdata = d_resp ? m_rdata : '0;
    end

    assign m_addr  = r_addr;
    assign m_wdata = r_wdata;

    sat_counter #(.W(32)) u_i_grant_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_grant_i),
        .o_count (i_grant_cnt)
    );

    sat_counter #(.W(32)) u_d_grant_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_grant_d),
        .o_count (d_grant_cnt)
    );

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: directed transactions, a memory responder
// that checks each issued access, and a monitor that checks every resp pulse.
module tb_cache_arbiter;
    import cache_arbiter_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         i_read;
    logic [31:0]  i_addr;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic         d_read;
    logic         d_write;
    logic [31:0]  d_addr;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic         m_read;
    logic         m_write;
    logic [31:0]  m_addr;
    logic [255:0] m_wdata;
    logic [255:0] m_rdata;
    logic         m_resp;
    logic [31:0]  i_grant_cnt;
    logic [31:0]  d_grant_cnt;

    logic         auto_resp;
    logic [255:0] auto_rdata;
    logic         man_resp;
    logic [255:0] man_rdata;
    bit           mem_auto;
    int           mem_lat;

    assign m_resp  = auto_resp | man_resp;
    assign m_rdata = auto_resp ? auto_rdata : man_rdata;

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
    } mem_exp_t;

    typedef struct {
        bit           side;
        logic [255:0] rdata;
    } resp_exp_t;

    mem_exp_t  exp_mem_q[$];
    resp_exp_t exp_resp_q[$];

    int n_pass;
    int n_total;

    cache_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_read      (i_read),
        .i_addr      (i_addr),
        .i_rdata     (i_rdata),
        .i_resp      (i_resp),
        .d_read      (d_read),
        .d_write     (d_write),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_resp      (d_resp),
        .m_read      (m_read),
        .m_write     (m_write),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_rdata     (m_rdata),
        .m_resp      (m_resp),
        .i_grant_cnt (i_grant_cnt),
        .d_grant_cnt (d_grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] rd_pat(input logic [31:0] a);
        return {8{a ^ 32'h5A5A_0000}};
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic push_txn(input bit side, input bit wr, input logic [31:0] addr, input logic [255:0] wdata);
        mem_exp_t  m;
        resp_exp_t r;
        m.wr = wr; m.addr = addr; m.wdata = wdata;
        r.side = side; r.rdata = rd_pat(addr);
        exp_mem_q.push_back(m);
        exp_resp_q.push_back(r);
    endtask

    task automatic wait_resp(input bit side, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if ((side ? d_resp : i_resp) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_total++;
            $display("FAIL %s_resp_timeout: got no pulse within %0d cycles", side ? "d" : "i", budget);
        end
    endtask

    // Memory responder: checks each new access against the expected queue, answers after mem_lat cycles.
    initial begin
        mem_exp_t e;
        auto_resp  = 1'b0;
        auto_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_auto && rst_n && (m_read || m_write)) begin
                if (exp_mem_q.size() == 0) begin
                    n_total++;
                    $display("FAIL mem_unexpected: got access addr %0h wr %0b, required none", m_addr, m_write);
                end else begin
                    e = exp_mem_q.pop_front();
                    chk("mem_addr", 256'(m_addr), 256'(e.addr));
                    chk("mem_write", 256'(m_write), 256'(e.wr));
                    chk("mem_read", 256'(m_read), 256'(!e.wr));
                    if (e.wr) chk("mem_wdata", m_wdata, e.wdata);
                end
                repeat (mem_lat - 1) @(posedge clk);
                #1;
                auto_resp  = 1'b1;
                auto_rdata = rd_pat(m_addr);
                @(posedge clk);
                #1;
                auto_resp  = 1'b0;
                auto_rdata = '0;
            end
        end
    end

    // Response monitor: every resp pulse must match the next expected completion.
    initial begin
        resp_exp_t r;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (i_resp && d_resp) begin
                    n_total++;
                    $display("FAIL both_resp: got i_resp=1 d_resp=1, required at most one");
                end
                if (i_resp || d_resp) begin
                    if (exp_resp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL resp_unexpected: got i_resp=%0b d_resp=%0b, required none", i_resp, d_resp);
                    end else begin
                        r = exp_resp_q.pop_front();
                        chk("resp_side", 256'(d_resp), 256'(r.side));
                        chk("resp_rdata", d_resp ? d_rdata : i_rdata, r.rdata);
                    end
                end
                if (!i_resp) chk("i_rdata_idle", i_rdata, '0);
                if (!d_resp) chk("d_rdata_idle", d_rdata, '0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bit ok_i;
        bit ok_d;
        int ni;
        int nd;
        n_pass = 0; n_total = 0;
        mem_auto = 1'b1; mem_lat = 3;
        man_resp = 1'b0; man_rdata = '0;
        i_read = 1'b0; i_addr = '0;
        d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_state", 256'(dut.r_state), 256'(ST_IDLE));
        chk("rst_last", 256'(dut.r_last), 256'(SIDE_I));
        chk("rst_m_read", 256'(m_read), '0);
        chk("rst_m_write", 256'(m_write), '0);
        chk("rst_m_addr", 256'(m_addr), '0);
        chk("rst_m_wdata", m_wdata, '0);
        chk("rst_i_cnt", 256'(i_grant_cnt), '0);
        chk("rst_d_cnt", 256'(d_grant_cnt), '0);
        chk("rst_i_resp", 256'(i_resp), '0);
        chk("rst_d_resp", 256'(d_resp), '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single I read, slow memory
        mem_lat = 10;
        push_txn(1'b0, 1'b0, 32'h0000_0060, '0);
        @(posedge clk); #1;
        i_addr = 32'h0000_0064; i_read = 1'b1;
        @(posedge clk); #1;
        chk("i_first_m_read", 256'(m_read), 256'(1));
        chk("i_first_m_addr", 256'(m_addr), 256'(32'h0000_0060));
        chk("i_first_state", 256'(dut.r_state), 256'(ST_I_BUSY));
        wait_resp(1'b0, 40, ok);
        @(posedge clk); #1;
        i_read = 1'b0;
        chk("i_release_state", 256'(dut.r_state), 256'(ST_RELEASE));
        chk("i_release_m_read", 256'(m_read), '0);
        @(posedge clk); #1;
        chk("i_idle_state", 256'(dut.r_state), 256'(ST_IDLE));
        chk("i_cnt_1", 256'(i_grant_cnt), 256'(1));
        mem_lat = 3;

        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Simultaneous requests after reset: D first, I in the IDLE after D's RELEASE
        push_txn(1'b1, 1'b0, 32'h0000_0340, '0);
        push_txn(1'b0, 1'b0, 32'h0000_0280, '0);
        @(posedge clk); #1;
        fork
            begin
                i_addr = 32'h0000_0288; i_read = 1'b1;
                wait_resp(1'b0, 100, ok_i);
                @(posedge clk); #1;
                i_read = 1'b0;
            end
            begin
                d_addr = 32'h0000_0340; d_read = 1'b1;
                wait_resp(1'b1, 100, ok_d);
                @(posedge clk); #1;
                d_read = 1'b0;
                chk("both_d_release", 256'(dut.r_state), 256'(ST_RELEASE));
                @(posedge clk); #1;
                chk("both_idle", 256'(dut.r_state), 256'(ST_IDLE));
                @(posedge clk); #1;
                chk("both_i_busy", 256'(dut.r_state), 256'(ST_I_BUSY));
            end
        join
        repeat (2) @(posedge clk); #1;
        chk("both_i_cnt", 256'(i_grant_cnt), 256'(1));
        chk("both_d_cnt", 256'(d_grant_cnt), 256'(1));

        // Continuous contention: strict alternation D,I,D,I...
        for (int g = 0; g < 4; g++) begin
            push_txn(1'b1, 1'b0, 32'h0000_0340, '0);
            push_txn(1'b0, 1'b0, 32'h0000_0280, '0);
        end
        @(posedge clk); #1;
        i_addr = 32'h0000_0288; d_addr = 32'h0000_0340;
        i_read = 1'b1; d_read = 1'b1;
        ni = 0; nd = 0;
        for (int k = 0; k < 200 && (ni < 4 || nd < 4); k++) begin
            @(negedge clk);
            if (i_resp) ni++;
            if (d_resp) nd++;
        end
        @(posedge clk); #1;
        i_read = 1'b0; d_read = 1'b0;
        chk("alt_i_resps", 256'(ni), 256'(4));
        chk("alt_d_resps", 256'(nd), 256'(4));
        repeat (2) @(posedge clk); #1;
        chk("alt_i_cnt", 256'(i_grant_cnt), 256'(5));
        chk("alt_d_cnt", 256'(d_grant_cnt), 256'(5));

        // D writeback, request dropped after grant must still complete
        push_txn(1'b1, 1'b1, 32'h0000_1000, {32{8'hA5}});
        @(posedge clk); #1;
        d_addr = 32'h0000_1000; d_wdata = {32{8'hA5}}; d_write = 1'b1;
        @(posedge clk); #1;
        d_write = 1'b0; d_wdata = '0; d_addr = '0;
        wait_resp(1'b1, 40, ok);
        chk("wr_hold_wdata", m_wdata, {32{8'hA5}});
        chk("wr_hold_m_write", 256'(m_write), 256'(1));
        repeat (3) @(posedge clk); #1;
        chk("wr_d_cnt", 256'(d_grant_cnt), 256'(6));

        // d_read and d_write together count as a write; low address bits cleared
        push_txn(1'b1, 1'b1, 32'h1234_5660, {8{32'hDEAD_BEEF}});
        @(posedge clk); #1;
        d_addr = 32'h1234_567F; d_wdata = {8{32'hDEAD_BEEF}};
        d_read = 1'b1; d_write = 1'b1;
        wait_resp(1'b1, 40, ok);
        @(posedge clk); #1;
        d_read = 1'b0; d_write = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("rw_d_cnt", 256'(d_grant_cnt), 256'(7));

        // Reset during D_BUSY, then a late m_resp
        mem_auto = 1'b0;
        @(posedge clk); #1;
        d_addr = 32'h0000_2000; d_wdata = {8{32'h1111_1111}}; d_write = 1'b1;
        @(posedge clk); #1;
        chk("rb_m_write_busy", 256'(m_write), 256'(1));
        #2;
        rst_n = 1'b0; d_write = 1'b0;
        #1;
        chk("rb_m_write_drop", 256'(m_write), '0);
        chk("rb_m_addr", 256'(m_addr), '0);
        chk("rb_m_wdata", m_wdata, '0);
        chk("rb_state", 256'(dut.r_state), 256'(ST_IDLE));
        chk("rb_i_cnt", 256'(i_grant_cnt), '0);
        chk("rb_d_cnt", 256'(d_grant_cnt), '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        man_resp = 1'b1; man_rdata = {8{32'hBAD0_BAD0}};
        @(negedge clk);
        chk("rb_late_d_resp", 256'(d_resp), '0);
        chk("rb_late_d_rdata", d_rdata, '0);
        @(posedge clk); #1;
        man_resp = 1'b0; man_rdata = '0;
        chk("rb_late_state", 256'(dut.r_state), 256'(ST_IDLE));
        chk("rb_late_m_write", 256'(m_write), '0);

        repeat (3) @(posedge clk); #1;
        chk("mem_q_empty", 256'(exp_mem_q.size()), '0);
        chk("resp_q_empty", 256'(exp_resp_q.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
